// File: rtl/sdm_nc_pkg.sv
// Shared types and helpers for the SDM noise-canceller controller.
// State encoding is fixed so it can be probed directly from the state register.
package sdm_nc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ADAPT  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Correlation needs to hold +/-2^win_log2 as a signed value.
  function automatic int corr_width(input int win_log2);
    return win_log2 + 2;
  endfunction

endpackage

// File: rtl/sdm_nc_corr.sv
// Sign-sign correlator: accumulates +/-1 per sample over a 2^WIN_LOG2 window.
// win_done and win_corr are presented combinationally with the closing sample.
module sdm_nc_corr
  import sdm_nc_pkg::*;
#(
  parameter int WIN_LOG2 = 6,
  parameter int CW       = corr_width(WIN_LOG2)
) (
  input  logic                 clk_ref,
  input  logic                 rstn,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic                 i_err_sign,
  input  logic                 i_q_sign,
  output logic                 o_win_done,
  output logic signed [CW-1:0] o_win_corr
);

  localparam logic signed [CW-1:0] C_ONE = CW'(1);

  logic signed [CW-1:0] r_corr;
  logic [WIN_LOG2-1:0]  r_cnt;
  logic signed [CW-1:0] w_corr_nxt;
  logic                 w_take;

  // Next accumulator value and end-of-window detection for the current sample.
  always_comb begin
    w_take = i_en & i_valid & ~i_clr;
    if (i_err_sign ^ i_q_sign) begin
      w_corr_nxt = r_corr + C_ONE;
    end else begin
      w_corr_nxt = r_corr - C_ONE;
    end
    o_win_done = w_take & (r_cnt == {WIN_LOG2{1'b1}});
    o_win_corr = w_corr_nxt;
  end

  // Accumulator and window counter; the closing sample restarts the window.
  always_ff @(posedge clk_ref or negedge rstn) begin
    if (!rstn) begin
      r_corr <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_corr <= '0;
      r_cnt  <= '0;
    end else if (w_take) begin
      r_cnt  <= r_cnt + WIN_LOG2'(1);
      r_corr <= o_win_done ? '0 : w_corr_nxt;
    end else begin
      r_corr <= r_corr;
      r_cnt  <= r_cnt;
    end
  end

endmodule

// File: rtl/sdm_nc_ctrl.sv
// Sequencer and sign-sign LMS gain controller for the SDM noise canceller.
// Runs IDLE -> SETTLE -> ADAPT <-> LOCKED; abort returns to IDLE with the gain held.
module sdm_nc_ctrl
  import sdm_nc_pkg::*;
#(
  parameter int W_GAIN     = 10,
  parameter int SETTLE_CYC = 64,
  parameter int WIN_LOG2   = 6,
  parameter int THR        = 4,
  parameter int LOCK_CNT   = 8
) (
  input  logic              clk_ref,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [W_GAIN-1:0] gain_init,
  input  logic [2:0]        step_sh,
  input  logic              err_valid,
  input  logic              err_sign,
  input  logic              q_sign,
  output logic              nc_enable,
  output logic [W_GAIN-1:0] nc_gain,
  output logic              busy,
  output logic              locked,
  output logic              gain_sat
);

  localparam int CW    = corr_width(WIN_LOG2);
  localparam int W_EXT = W_GAIN + 9;
  localparam int W_SET = $clog2(SETTLE_CYC + 1);
  localparam int W_LCK = $clog2(LOCK_CNT + 1);

  localparam logic signed [CW-1:0] C_THR  = CW'(THR);
  localparam logic signed [CW-1:0] C_THR2 = CW'(2 * THR);
  localparam logic [W_EXT-1:0]     C_GMAX = W_EXT'((1 << W_GAIN) - 1);

  state_t               r_state;
  logic [W_GAIN-1:0]    r_gain;
  logic                 r_sat;
  logic [W_SET-1:0]     r_settle;
  logic [W_LCK-1:0]     r_lock;
  logic                 r_nc_enable;
  logic                 r_busy;
  logic                 r_locked;

  state_t               w_state_nxt;
  logic [W_GAIN-1:0]    w_gain_nxt;
  logic                 w_sat_nxt;
  logic [W_SET-1:0]     w_settle_nxt;
  logic [W_LCK-1:0]     w_lock_nxt;

  logic                 w_corr_en;
  logic                 w_corr_clr;
  logic                 w_win_done;
  logic signed [CW-1:0] w_win_corr;
  logic [W_EXT-1:0]     w_step;
  logic [W_EXT-1:0]     w_up;
  logic [W_EXT-1:0]     w_dn;
  logic                 w_pos;
  logic                 w_neg;
  logic                 w_big;

  assign w_corr_en  = (r_state == ST_ADAPT) || (r_state == ST_LOCKED);
  assign w_corr_clr = abort || !w_corr_en;

  sdm_nc_corr #(
    .WIN_LOG2 (WIN_LOG2),
    .CW       (CW)
  ) u_corr (
    .clk_ref    (clk_ref),
    .rstn       (rstn),
    .i_clr      (w_corr_clr),
    .i_en       (w_corr_en),
    .i_valid    (err_valid),
    .i_err_sign (err_sign),
    .i_q_sign   (q_sign),
    .o_win_done (w_win_done),
    .o_win_corr (w_win_corr)
  );

  // Next-state, gain update with saturation, and settle/lock counters.
  always_comb begin
    w_state_nxt  = r_state;
    w_gain_nxt   = r_gain;
    w_sat_nxt    = r_sat;
    w_settle_nxt = r_settle;
    w_lock_nxt   = r_lock;

    w_step = W_EXT'(1) << step_sh;
    w_up   = W_EXT'(r_gain) + w_step;
    w_dn   = W_EXT'(r_gain) - w_step;
    w_pos  = w_win_corr > C_THR;
    w_neg  = w_win_corr < -C_THR;
    w_big  = (w_win_corr > C_THR2) || (w_win_corr < -C_THR2);

    if (abort) begin
      w_state_nxt  = ST_IDLE;
      w_settle_nxt = '0;
      w_lock_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt  = ST_SETTLE;
            w_gain_nxt   = gain_init;
            w_sat_nxt    = 1'b0;
            w_settle_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (r_settle == W_SET'(SETTLE_CYC - 1)) begin
            w_state_nxt  = ST_ADAPT;
            w_settle_nxt = '0;
            w_lock_nxt   = '0;
          end else begin
            w_settle_nxt = r_settle + W_SET'(1);
          end
        end
        ST_ADAPT: begin
          if (w_win_done) begin
            // w_dn goes negative in W_EXT bits when the step exceeds the gain.
            if (w_pos) begin
              if (w_up > C_GMAX) begin
                w_gain_nxt = C_GMAX[W_GAIN-1:0];
                w_sat_nxt  = 1'b1;
              end else begin
                w_gain_nxt = w_up[W_GAIN-1:0];
              end
            end else if (w_neg) begin
              if ($signed(w_dn) < $signed(W_EXT'(0))) begin
                w_gain_nxt = '0;
                w_sat_nxt  = 1'b1;
              end else begin
                w_gain_nxt = w_dn[W_GAIN-1:0];
              end
            end else begin
              w_gain_nxt = r_gain;
            end
            if (!w_pos && !w_neg) begin
              if (r_lock == W_LCK'(LOCK_CNT - 1)) begin
                w_lock_nxt  = W_LCK'(LOCK_CNT);
                w_state_nxt = ST_LOCKED;
              end else begin
                w_lock_nxt = r_lock + W_LCK'(1);
              end
            end else begin
              w_lock_nxt = '0;
            end
          end else begin
            w_state_nxt = ST_ADAPT;
          end
        end
        ST_LOCKED: begin
          if (w_win_done && w_big) begin
            w_state_nxt = ST_ADAPT;
            w_lock_nxt  = '0;
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_settle_nxt = '0;
          w_lock_nxt   = '0;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk_ref or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_gain      <= '0;
      r_sat       <= 1'b0;
      r_settle    <= '0;
      r_lock      <= '0;
      r_nc_enable <= 1'b0;
      r_busy      <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gain      <= w_gain_nxt;
      r_sat       <= w_sat_nxt;
      r_settle    <= w_settle_nxt;
      r_lock      <= w_lock_nxt;
      r_nc_enable <= (w_state_nxt != ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_locked    <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign nc_enable = r_nc_enable;
  assign nc_gain   = r_gain;
  assign busy      = r_busy;
  assign locked    = r_locked;
  assign gain_sat  = r_sat;

endmodule
